serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes DIFF = A − B one bit per clock, LSB first.
- Uses a single borrow flip-flop; this is the ripple-borrow counterpart of the team's full adder cells.
- Sits beside the adder datapath in area-constrained paths where a parallel subtractor is too large.
- Start/busy/done handshake; result held stable until the next accepted START.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset, asynchronous, active-low.
- START  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; sampled on the accepting edge.
- B  input  WIDTH  subtrahend; sampled on the accepting edge.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  one-cycle pulse when the result is valid.
- DIFF  output  WIDTH  A − B modulo 2^WIDTH.
- BORROW_OUT  output  1  unsigned borrow; 1 when A < B unsigned.
- OVERFLOW  output  1  signed overflow of A − B.

Behaviour:
- Reset (RST_N low, asynchronous): state = IDLE; BUSY = 0, DONE = 0, DIFF = 0, BORROW_OUT = 0, OVERFLOW = 0. Internal shift registers, borrow flop and bit counter are cleared.
- FSM states: IDLE, SHIFT, FINISH.
  - IDLE: on an edge with START = 1, latch A and B into shift registers, clear the borrow flop and the counter, go to SHIFT. DIFF, BORROW_OUT and OVERFLOW are held from the previous operation until this edge, then are not guaranteed until DONE.
  - SHIFT: BUSY = 1. Each edge processes bit i = counter.
    - d = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d shifts into the result register from the MSB side.
    - Counter increments; after the WIDTH-th SHIFT edge, go to FINISH.
  - FINISH: DONE = 1, BUSY = 0 for exactly one cycle.
    - DIFF is the full result.
    - BORROW_OUT = final borrow.
    - OVERFLOW = (A[MSB] != B[MSB]) && (DIFF[MSB] != A[MSB]), using the latched A and B.
    - Next edge goes to IDLE.
- Latency: if START is accepted at edge 0, DONE is high during the cycle following edge WIDTH and low after edge WIDTH+1.
  - Earliest next accept is edge WIDTH+2, since START is only sampled in IDLE.
- START while BUSY or in FINISH: ignored entirely. No queuing; the result is unaffected.
- A and B may change freely after the accepting edge without affecting the result.
- Outputs are registered: DIFF, BORROW_OUT and OVERFLOW are driven from flops, with no combinational path from inputs.
- After DONE, DIFF, BORROW_OUT and OVERFLOW hold until the next accepted START.
- Reset mid-operation: abort immediately, return to the reset values above. No DONE pulse is produced for the aborted operation.
- Counter width: $clog2(WIDTH+1) bits. No wrap occurs within an operation.
- Equivalence: the result must equal A + ~B + 1 truncated to WIDTH bits, with BORROW_OUT = ~carry_out of that sum.

Test Plan:
- WIDTH=8, A=0x35, B=0x12, START one cycle -> DONE pulses 1 cycle after the 8th SHIFT edge; DIFF=0x23, BORROW_OUT=0, OVERFLOW=0; BUSY high for exactly 8 cycles.
- A=0x00, B=0x01 -> DIFF=0xFF, BORROW_OUT=1, OVERFLOW=0. A=0x80, B=0x01 -> DIFF=0x7F, BORROW_OUT=0, OVERFLOW=1.
- A=0x7F, B=0xFF -> DIFF=0x80, BORROW_OUT=1, OVERFLOW=1. A=B=0xA5 -> DIFF=0x00, BORROW_OUT=0, OVERFLOW=0.
- START held high continuously with A/B changed every cycle -> operations are accepted only at IDLE edges, spaced WIDTH+2 cycles apart; each DIFF matches the operands present at its own accepting edge.
- Start A=0x35, B=0x12, then assert RST_N low for 1 cycle at the 4th SHIFT cycle -> all outputs 0 asynchronously, no DONE pulse; a new START with A=0x10, B=0x20 -> DIFF=0xF0, BORROW_OUT=1.
- Randomized sweep of 1000 operand pairs, for WIDTH=8 and for WIDTH=5 -> DIFF, BORROW_OUT and OVERFLOW match the reference model; DIFF stays stable between DONE and the next accept.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B, one bit per clock, LSB first.
// A single borrow flop ripples between bit slices; START/BUSY/DONE handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o,
  output logic             overflow_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             busy_q;
  logic             done_q;
  logic             borrow_q;
  logic             ovf_q;

  logic             diff_bit_d;
  logic             br_d;
  logic             last_c;

  // One full-subtractor slice on the current LSBs of the operand shifters.
  always_comb begin
    diff_bit_d = a_q[0] ^ b_q[0] ^ br_q;
    br_d       = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_c     = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= br_d;
          diff_q <= {diff_bit_d, diff_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + CW'(1);
          if (last_c) begin
            // On the last slice the shifter LSBs hold the operand sign bits.
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            borrow_q <= br_d;
            ovf_q    <= (a_q[0] != b_q[0]) && (diff_bit_d != a_q[0]);
            state_q  <= FINISH;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign diff_o       = diff_q;
  assign borrow_out_o = borrow_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 (directed, held-START, reset-abort,
// random) and an independent WIDTH=5 random sweep, both against an arithmetic model.
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int W5 = 5;

  typedef struct {
    int d;
    bit br;
    bit ov;
    int due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, rst5_n;
  logic         start, start5;
  logic [W-1:0] a, b;
  logic [W5-1:0] a5, b5;
  logic         busy_o, done_o, borrow_o, ovf_o;
  logic [W-1:0] diff_o;
  logic         busy5_o, done5_o, borrow5_o, ovf5_o;
  logic [W5-1:0] diff5_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q[$];
  exp_t q5[$];
  bit   fin5 = 1'b0;

  bit   hold_chk = 1'b0;
  exp_t hold_e;
  int   busy_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b),
    .busy_o(busy_o), .done_o(done_o), .diff_o(diff_o),
    .borrow_out_o(borrow_o), .overflow_o(ovf_o)
  );

  serial_subtractor #(.WIDTH(W5)) dut5 (
    .clk(clk), .rst_n(rst5_n), .start_i(start5), .a_i(a5), .b_i(b5),
    .busy_o(busy5_o), .done_o(done5_o), .diff_o(diff5_o),
    .borrow_out_o(borrow5_o), .overflow_o(ovf5_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
    $fatal(1);
  end

  // Reference: plain modular / signed integer arithmetic.
  function automatic exp_t model(int w, int av, int bv, int due);
    exp_t e;
    int   m  = 1 << w;
    int   sa = (av >= (m / 2)) ? av - m : av;
    int   sb = (bv >= (m / 2)) ? bv - m : bv;
    int   s  = sa - sb;
    e.d   = (av - bv + m) % m;
    e.br  = (av < bv);
    e.ov  = (s > (m / 2) - 1) || (s < -(m / 2));
    e.due = due;
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drain8(int lim);
    int n = 0;
    while (q.size() != 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout8: got %0d pending results expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_op(int av, int bv);
    @(posedge clk); #1;
    a     = W'(av);
    b     = W'(bv);
    start = 1'b1;
    q.push_back(model(W, av, bv, cyc + 1 + W));
    @(posedge clk); #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    drain8(W + 6);
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_chk = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy_o) busy_cnt++;
      if (hold_chk) begin
        chk("hold_diff", int'(diff_o), hold_e.d);
        chk("hold_borrow", int'(borrow_o), int'(hold_e.br));
      end
      if (done_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("diff", int'(diff_o), e.d);
          chk("borrow_out", int'(borrow_o), int'(e.br));
          chk("overflow", int'(ovf_o), int'(e.ov));
          chk("done_cycle", cyc, e.due);
          chk("busy_cycles", busy_cnt, W);
          hold_chk = 1'b1;
          hold_e   = e;
        end
        busy_cnt = 0;
      end
      if (start) hold_chk = 1'b0;
    end
  end

  // Monitor for the 5-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst5_n && done5_o) begin
      if (q5.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done5: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q5.pop_front();
        chk("diff5", int'(diff5_o), e.d);
        chk("borrow_out5", int'(borrow5_o), int'(e.br));
        chk("overflow5", int'(ovf5_o), int'(e.ov));
        chk("done_cycle5", cyc, e.due);
      end
    end
  end

  // 5-bit random sweep, runs concurrently with the 8-bit sequence.
  initial begin
    int av, bv, n;
    rst5_n = 1'b0;
    start5 = 1'b0;
    a5 = '0;
    b5 = '0;
    repeat (3) @(posedge clk);
    #1 rst5_n = 1'b1;
    repeat (1000) begin
      @(posedge clk); #1;
      av = int'($urandom_range(31, 0));
      bv = int'($urandom_range(31, 0));
      a5 = W5'(av);
      b5 = W5'(bv);
      start5 = 1'b1;
      q5.push_back(model(W5, av, bv, cyc + 1 + W5));
      @(posedge clk); #1;
      start5 = 1'b0;
      a5 = W5'($urandom);
      b5 = W5'($urandom);
      n = 0;
      while (q5.size() != 0 && n < W5 + 6) begin
        @(posedge clk);
        n++;
      end
      if (q5.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL done_timeout5: got %0d pending results expected 0", q5.size());
        q5.delete();
      end
    end
    fin5 = 1'b1;
  end

  initial begin
    int da[5] = '{'h35, 'h00, 'h80, 'h7F, 'hA5};
    int db[5] = '{'h12, 'h01, 'h01, 'hFF, 'hA5};
    int c0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_diff", int'(diff_o), 0);
    chk("rst_borrow", int'(borrow_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) do_op(da[i], db[i]);

    // START held high with operands changing each cycle.
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < 3 * (W + 2); k++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (k % (W + 2) == 0) q.push_back(model(W, int'(a), int'(b), cyc + 1 + W));
      @(posedge clk); #1;
    end
    start = 1'b0;
    drain8(3 * (W + 4));

    // Reset during the 4th SHIFT cycle aborts without a DONE pulse.
    @(posedge clk); #1;
    c0 = cyc;
    a = W'('h35);
    b = W'('h12);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < c0 + 4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_done", int'(done_o), 0);
    chk("abort_diff", int'(diff_o), 0);
    chk("abort_borrow", int'(borrow_o), 0);
    chk("abort_ovf", int'(ovf_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (W + 3) @(posedge clk);
    do_op('h10, 'h20);

    repeat (1000) do_op(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));

    wait (fin5);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
